l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Shares one L2 line port among NREQ L1 caches (e.g. I$ req0, D$ req1). Uses the same
//  valid/ready line-request + resp_valid line-response protocol on every side.
//  Round-robin grant; one downstream transaction in flight; read responses routed to issuer.
//  Sits between the L1 caches' l2_* ports and the L2 cache/memory controller.
// PARAMETERS
//  NREQ       2    number of upstream L1 requesters (>=2)
//  ADDR_W     32   byte address width (line aligned)
//  L1_LINE_W  256  line width in bits
// PORTS
//  clk             in   1               clock; all logic on posedge
//  rst             in   1               synchronous, active-high reset
//  up_req_valid    in   NREQ            per-requester line request valid
//  up_req_ready    out  NREQ            per-requester accept (one-hot or zero)
//  up_req_rw       in   NREQ            0=readline, 1=writeline
//  up_req_addr     in   NREQ x ADDR_W   line address
//  up_req_wline    in   NREQ x L1_LINE_W write line data
//  up_resp_valid   out  NREQ            read response strobe to owner only
//  up_resp_rline   out  L1_LINE_W       read line, broadcast (qualified by up_resp_valid)
//  dn_req_valid    out  1               request to L2
//  dn_req_ready    in   1               L2 accept
//  dn_req_rw       out  1               0=readline, 1=writeline
//  dn_req_addr     out  ADDR_W          line address
//  dn_req_wline    out  L1_LINE_W       write line data
//  dn_resp_valid   in   1               L2 read response strobe
//  dn_resp_rline   in   L1_LINE_W       L2 read line
//  busy            out  1               state != S_IDLE
//  err_spur_resp   out  1               sticky: dn_resp_valid seen outside S_RESP_WAIT
// BEHAVIOUR
//  Reset: state=S_IDLE, rr_ptr=0, owner=0, dn_req_valid=0, dn_req_*=0, err_spur_resp=0;
//   up_req_ready/up_resp_valid=0 (combinational, zero in S_IDLE). Reset mid-transaction
//   abandons it; a late dn_resp_valid after reset sets err_spur_resp.
//  FSM (2-bit enum): S_IDLE -> S_ISSUE -> (rw ? S_IDLE : S_RESP_WAIT) -> S_IDLE.
//  S_IDLE: if any up_req_valid: winner = first valid index at or after rr_ptr (wrap mod NREQ);
//   register owner, dn_req_{rw,addr,wline} from winner, dn_req_valid<=1; go S_ISSUE.
//   Grant latency: 1 cycle from up_req_valid to dn_req_valid.
//  S_ISSUE: dn_req_* held stable until dn_req_ready. up_req_ready[owner]=dn_req_ready (comb),
//   so the L1 handshake completes in the same cycle as the L2 handshake. On handshake:
//   dn_req_valid<=0, rr_ptr<=owner+1 (wrap at NREQ); write -> S_IDLE, read -> S_RESP_WAIT.
//  S_RESP_WAIT: no new grant. up_resp_valid[owner]=dn_resp_valid, up_resp_rline=dn_resp_rline
//   (comb, zero latency); on dn_resp_valid -> S_IDLE.
//  Writeback-then-refill from one L1 is two separate grants; another requester may win
//   between them (round-robin fairness; no lock).
//  Simultaneous requests: rr_ptr decides; a requester waits at most NREQ-1 transactions.
//  up_req_valid dropping while unowned: ignored. Owner may not drop valid in S_ISSUE (protocol).
//  dn_resp_valid in S_IDLE/S_ISSUE: dropped, err_spur_resp<=1 (cleared only by rst).
//  Back-to-back: S_IDLE always spends 1 cycle; peak throughput 1 write per 2 cycles.
// CONFIGURATION
//  L2ARB_STATS_EN defined: adds outputs stat_grants [NREQ x 32] (per-requester accepted
//   transactions, wrap at 2^32) and stat_wait_cyc [32] (cycles any up_req_valid is high but
//   not owner-granted); incremented on dn handshake / each such cycle; cleared by rst.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package l2_arb_pkg: state_t enum {S_IDLE,S_ISSUE,S_RESP_WAIT}; line-request struct
//   {rw, addr, wline} parameterised via localparams ADDR_W/L1_LINE_W defaults.
//  Sub-module rr_pick (comb): inputs req[NREQ], ptr -> onehot grant + index; reusable.
// TESTING
//  Single read: req0 read 0x0000_0040, L2 ready same cycle, resp 3 cycles later with
//   line 0xA5.. -> up_resp_valid[0] 1 cycle, rline=0xA5.., up_resp_valid[1]=0.
//  Contention: req0/req1 both write from reset -> req0 granted first, req1 next; then both
//   again -> req0 (ptr=0 after req1) ; grants alternate 0,1,0,1.
//  Backpressure: dn_req_ready low 5 cycles -> dn_req_* stable, up_req_ready=0 throughout,
//   ready pulse coincides with dn handshake.
//  Writeback+refill: req1 write 0x100 then read 0x200 while req0 read 0x300 pending ->
//   order 1W,0R,1R; each read response routed to its owner only.
//  Spurious/reset: dn_resp_valid in S_IDLE -> err_spur_resp=1, no up_resp_valid; rst in
//   S_RESP_WAIT -> all outputs 0 next cycle, busy=0.
//  STATS (with L2ARB_STATS_EN): 4 grants to req0, 3 to req1 -> stat_grants={4,3}.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and default widths for the L2 port arbiter
// Contents:
//   ADDR_W, L1_LINE_W : default byte-address and line widths
//   state_t           : arbiter FSM state encoding
//   line_req_t        : one line request {rw, addr, wline} at the default widths
package l2_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int L1_LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_RESP_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic                 rw;     // 0 = readline, 1 = writeline
    logic [ADDR_W-1:0]    addr;
    logic [L1_LINE_W-1:0] wline;
  } line_req_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  highest-priority index this round (must be < NREQ)
//   grant out NREQ   one-hot grant, zero when no request
//   idx   out IDX_W  index of the granted request
//   any   out 1      at least one request present
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters starting at ptr and wrapping; the first one found wins.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - round-robin arbiter sharing one L2 line port among NREQ L1 caches
// Optional feature macro: L2ARB_STATS_EN (adds stat_grants / stat_wait_cyc counters).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   up_req_*        per-requester line request (valid/ready, rw, addr, wline)
//   up_resp_valid   read response strobe, only to the requester that issued the read
//   up_resp_rline   read line, shared by all requesters, zero outside S_RESP_WAIT
//   dn_req_*        single downstream line request to the L2 (registered)
//   dn_resp_*       L2 read response
//   busy            FSM not in S_IDLE
//   err_spur_resp   sticky, L2 response arrived while no read was outstanding
//   stat_grants     (L2ARB_STATS_EN) accepted transactions per requester
//   stat_wait_cyc   (L2ARB_STATS_EN) cycles where some valid requester was not accepted
module l2_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = l2_arb_pkg::ADDR_W,
  parameter int L1_LINE_W = l2_arb_pkg::L1_LINE_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 up_req_valid,
  output logic [NREQ-1:0]                 up_req_ready,
  input  logic [NREQ-1:0]                 up_req_rw,
  input  logic [NREQ-1:0][ADDR_W-1:0]     up_req_addr,
  input  logic [NREQ-1:0][L1_LINE_W-1:0]  up_req_wline,
  output logic [NREQ-1:0]                 up_resp_valid,
  output logic [L1_LINE_W-1:0]            up_resp_rline,
  output logic                            dn_req_valid,
  input  logic                            dn_req_ready,
  output logic                            dn_req_rw,
  output logic [ADDR_W-1:0]               dn_req_addr,
  output logic [L1_LINE_W-1:0]            dn_req_wline,
  input  logic                            dn_resp_valid,
  input  logic [L1_LINE_W-1:0]            dn_resp_rline,
  output logic                            busy,
`ifdef L2ARB_STATS_EN
  output logic [NREQ-1:0][31:0]           stat_grants,
  output logic [31:0]                     stat_wait_cyc,
`endif
  output logic                            err_spur_resp
);

  import l2_arb_pkg::state_t;
  import l2_arb_pkg::S_IDLE;
  import l2_arb_pkg::S_ISSUE;
  import l2_arb_pkg::S_RESP_WAIT;

  localparam int IDX_W = $clog2(NREQ);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] owner_inc;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             dn_hs;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (up_req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // dn_req_valid is high for the whole of S_ISSUE, so the L2 handshake is
  // simply "in S_ISSUE and the L2 is ready".
  assign dn_hs     = (state == S_ISSUE) && dn_req_ready;
  assign owner_inc = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (pick_any)      state_nx = S_ISSUE;
      S_ISSUE:     if (dn_req_ready)  state_nx = dn_req_rw ? S_IDLE : S_RESP_WAIT;
      S_RESP_WAIT: if (dn_resp_valid) state_nx = S_IDLE;
      default:                        state_nx = S_IDLE;
    endcase
  end

  // Upstream ready and response are combinational so the L1 handshake lands
  // in the same cycle as the L2 one, and read data passes through with no
  // added latency.
  always_comb begin
    up_req_ready  = '0;
    up_resp_valid = '0;
    up_resp_rline = '0;
    if (state == S_ISSUE) begin
      up_req_ready[owner] = dn_req_ready;
    end
    if (state == S_RESP_WAIT) begin
      up_resp_valid[owner] = dn_resp_valid;
      up_resp_rline        = dn_resp_rline;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      owner         <= '0;
      dn_req_valid  <= 1'b0;
      dn_req_rw     <= 1'b0;
      dn_req_addr   <= '0;
      dn_req_wline  <= '0;
      err_spur_resp <= 1'b0;
    end else begin
      if ((state == S_IDLE) && pick_any) begin
        owner        <= pick_idx;
        dn_req_valid <= 1'b1;
        dn_req_rw    <= up_req_rw[pick_idx];
        dn_req_addr  <= up_req_addr[pick_idx];
        dn_req_wline <= up_req_wline[pick_idx];
      end
      if (dn_hs) begin
        dn_req_valid <= 1'b0;
        rr_ptr       <= owner_inc;
      end
      // A response with no read outstanding is dropped and flagged.
      if (dn_resp_valid && (state != S_RESP_WAIT)) begin
        err_spur_resp <= 1'b1;
      end
    end
  end

`ifdef L2ARB_STATS_EN
  logic wait_cyc;

  assign wait_cyc = |(up_req_valid & ~up_req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants   <= '0;
      stat_wait_cyc <= '0;
    end else begin
      if (dn_hs) begin
        stat_grants[owner] <= stat_grants[owner] + 32'd1;
      end
      if (wait_cyc) begin
        stat_wait_cyc <= stat_wait_cyc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;
  import l2_arb_pkg::*;

  localparam int NREQ   = 2;
  localparam int MAXCYC = 300;

  logic                           clk;
  logic                           rst;
  logic [NREQ-1:0]                up_req_valid;
  logic [NREQ-1:0]                up_req_ready;
  logic [NREQ-1:0]                up_req_rw;
  logic [NREQ-1:0][ADDR_W-1:0]    up_req_addr;
  logic [NREQ-1:0][L1_LINE_W-1:0] up_req_wline;
  logic [NREQ-1:0]                up_resp_valid;
  logic [L1_LINE_W-1:0]           up_resp_rline;
  logic                           dn_req_valid;
  logic                           dn_req_ready;
  logic                           dn_req_rw;
  logic [ADDR_W-1:0]              dn_req_addr;
  logic [L1_LINE_W-1:0]           dn_req_wline;
  logic                           dn_resp_valid;
  logic [L1_LINE_W-1:0]           dn_resp_rline;
  logic                           busy;
  logic                           err_spur_resp;
`ifdef L2ARB_STATS_EN
  logic [NREQ-1:0][31:0]          stat_grants;
  logic [31:0]                    stat_wait_cyc;
`endif

  l2_port_arbiter #(
    .NREQ      (NREQ),
    .ADDR_W    (ADDR_W),
    .L1_LINE_W (L1_LINE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up_req_valid  (up_req_valid),
    .up_req_ready  (up_req_ready),
    .up_req_rw     (up_req_rw),
    .up_req_addr   (up_req_addr),
    .up_req_wline  (up_req_wline),
    .up_resp_valid (up_resp_valid),
    .up_resp_rline (up_resp_rline),
    .dn_req_valid  (dn_req_valid),
    .dn_req_ready  (dn_req_ready),
    .dn_req_rw     (dn_req_rw),
    .dn_req_addr   (dn_req_addr),
    .dn_req_wline  (dn_req_wline),
    .dn_resp_valid (dn_resp_valid),
    .dn_resp_rline (dn_resp_rline),
    .busy          (busy),
`ifdef L2ARB_STATS_EN
    .stat_grants   (stat_grants),
    .stat_wait_cyc (stat_wait_cyc),
`endif
    .err_spur_resp (err_spur_resp)
  );

  typedef struct {
    int        src;
    line_req_t r;
  } exp_t;

  typedef struct {
    int                   src;
    logic [L1_LINE_W-1:0] line;
  } rexp_t;

  typedef struct {
    int                   src;
    logic                 rw;
    logic [ADDR_W-1:0]    addr;
    logic [L1_LINE_W-1:0] wline;
    int                   stall;
    int                   rdly;
  } vec_t;

  line_req_t            req_q[NREQ][$];
  exp_t                 exp_q[$];
  rexp_t                resp_q[$];
  exp_t                 mon_e;
  rexp_t                mon_re;
  logic [NREQ-1:0]      agent_hs;
  logic                 l2_hs;
  logic                 l2_vseen;
  logic                 l2_rw;
  logic [ADDR_W-1:0]    l2_addr;
  int                   stall_cfg;
  int                   stall_left;
  int                   rdly_cfg;
  int                   resp_cnt;
  int                   stall_cycles;
  logic                 resp_pend;
  logic [L1_LINE_W-1:0] resp_line;
  logic                 spur_mode;
  int                   n_checks;
  int                   n_pass;
  vec_t                 vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [L1_LINE_W-1:0] line_fn(input logic [ADDR_W-1:0] a);
    return {(L1_LINE_W / ADDR_W){a ^ 32'hA5A5_A5A5}};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int s);
    return NREQ'(1) << s;
  endfunction

  task automatic chk(input string name, input logic [L1_LINE_W-1:0] act,
                     input logic [L1_LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_req(input int src, input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [L1_LINE_W-1:0] w);
    line_req_t r;
    r.rw = rw; r.addr = a; r.wline = w;
    req_q[src].push_back(r);
  endtask

  task automatic push_exp(input int src, input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [L1_LINE_W-1:0] w);
    exp_t e;
    e.src = src; e.r.rw = rw; e.r.addr = a; e.r.wline = w;
    exp_q.push_back(e);
  endtask

  task automatic push_txn(input int src, input logic rw, input logic [ADDR_W-1:0] a,
                          input logic [L1_LINE_W-1:0] w);
    push_req(src, rw, a, w);
    push_exp(src, rw, a, w);
  endtask

  function automatic logic pending();
    logic p;
    p = (exp_q.size() != 0) || (resp_q.size() != 0) || resp_pend || busy;
    for (int i = 0; i < NREQ; i++) p = p || (req_q[i].size() != 0);
    return p;
  endfunction

  task automatic drain(input string name);
    int c;
    c = 0;
    while (pending() && c < MAXCYC) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_timeout"}, L1_LINE_W'(c >= MAXCYC), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    up_req_valid = '0;
    dn_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) req_q[i].delete();
    exp_q.delete();
    resp_q.delete();
    resp_pend = 1'b0;
    spur_mode = 1'b0;
    stall_cfg = 0;
    stall_left = 0;
    rdly_cfg = 2;
    dn_req_ready = 1'b1;
    dn_resp_valid = 1'b0;
    up_req_valid = '0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    up_req_valid = '0;
    up_req_rw = '0;
    up_req_addr = '0;
    up_req_wline = '0;
    dn_req_ready = 1'b1;
    dn_resp_valid = 1'b0;
    dn_resp_rline = '0;
    agent_hs = '0;
    l2_hs = 1'b0;
    l2_vseen = 1'b0;
    l2_rw = 1'b0;
    l2_addr = '0;
    stall_cfg = 0;
    stall_left = 0;
    rdly_cfg = 2;
    resp_cnt = 0;
    resp_pend = 1'b0;
    resp_line = '0;
    spur_mode = 1'b0;
    stall_cycles = 0;
    n_checks = 0;
    n_pass = 0;

    vecs[0] = '{1, 1'b1, 32'h0000_1000, {8{32'h1111_2222}}, 0, 0};
    vecs[1] = '{0, 1'b1, 32'h0000_2040, {8{32'hDEAD_BEEF}}, 3, 0};
    vecs[2] = '{1, 1'b0, 32'h0000_00C0, '0,                 0, 0};
    vecs[3] = '{0, 1'b0, 32'hFFFF_FFC0, '0,                 2, 5};
    vecs[4] = '{1, 1'b0, 32'h0000_3000, '0,                 1, 1};
    vecs[5] = '{0, 1'b1, 32'hFFFF_FFE0, '1,                 0, 0};

    fork
      // Monitor / scoreboard at the falling edge.
      forever begin
        @(negedge clk);
        agent_hs = up_req_valid & up_req_ready;
        l2_hs    = dn_req_valid & dn_req_ready;
        l2_vseen = dn_req_valid;
        l2_rw    = dn_req_rw;
        l2_addr  = dn_req_addr;
        if (!rst) begin
          if (dn_req_valid && dn_req_ready) begin
            if (exp_q.size() == 0) begin
              chk("dn_hs_unexpected", L1_LINE_W'(dn_req_valid), '0);
            end else begin
              mon_e = exp_q.pop_front();
              chk("grant_owner", L1_LINE_W'(up_req_ready), L1_LINE_W'(onehot(mon_e.src)));
              chk("dn_rw", L1_LINE_W'(dn_req_rw), L1_LINE_W'(mon_e.r.rw));
              chk("dn_addr", L1_LINE_W'(dn_req_addr), L1_LINE_W'(mon_e.r.addr));
              chk("dn_wline", dn_req_wline, mon_e.r.wline);
              if (!mon_e.r.rw) begin
                mon_re.src  = mon_e.src;
                mon_re.line = line_fn(mon_e.r.addr);
                resp_q.push_back(mon_re);
              end
            end
          end else if (dn_req_valid) begin
            stall_cycles++;
            chk("stall_ready_low", L1_LINE_W'(up_req_ready), '0);
            if (exp_q.size() != 0) begin
              chk("stall_addr_stable", L1_LINE_W'(dn_req_addr), L1_LINE_W'(exp_q[0].r.addr));
              chk("stall_wline_stable", dn_req_wline, exp_q[0].r.wline);
            end
          end
          if (dn_resp_valid && !spur_mode) begin
            if (resp_q.size() == 0) begin
              chk("resp_unexpected", L1_LINE_W'(dn_resp_valid), '0);
            end else begin
              mon_re = resp_q.pop_front();
              chk("resp_route", L1_LINE_W'(up_resp_valid), L1_LINE_W'(onehot(mon_re.src)));
              chk("resp_line", up_resp_rline, mon_re.line);
            end
          end else if (!dn_resp_valid && up_resp_valid != '0) begin
            chk("resp_no_strobe", L1_LINE_W'(up_resp_valid), '0);
          end
        end
      end
      // Requester agents and L2 model, driven just after the rising edge.
      forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
          if (agent_hs[i] && req_q[i].size() != 0) req_q[i].delete(0);
          if (req_q[i].size() != 0) begin
            up_req_valid[i] = 1'b1;
            up_req_rw[i]    = req_q[i][0].rw;
            up_req_addr[i]  = req_q[i][0].addr;
            up_req_wline[i] = req_q[i][0].wline;
          end else begin
            up_req_valid[i] = 1'b0;
          end
        end
        agent_hs = '0;
        if (l2_hs) begin
          stall_left = stall_cfg;
          if (!l2_rw && !spur_mode) begin
            resp_pend = 1'b1;
            resp_cnt  = rdly_cfg;
            resp_line = line_fn(l2_addr);
          end
        end else if (l2_vseen && stall_left > 0) begin
          stall_left--;
        end
        l2_hs = 1'b0;
        l2_vseen = 1'b0;
        dn_req_ready = (stall_left == 0);
        if (!spur_mode) begin
          dn_resp_valid = 1'b0;
          if (resp_pend) begin
            if (resp_cnt == 0) begin
              dn_resp_valid = 1'b1;
              dn_resp_rline = resp_line;
              resp_pend = 1'b0;
            end else begin
              resp_cnt--;
            end
          end
        end
      end
    join_none

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst_busy", L1_LINE_W'(busy), '0);
    chk("rst_dn_valid", L1_LINE_W'(dn_req_valid), '0);
    chk("rst_dn_rw", L1_LINE_W'(dn_req_rw), '0);
    chk("rst_dn_addr", L1_LINE_W'(dn_req_addr), '0);
    chk("rst_dn_wline", dn_req_wline, '0);
    chk("rst_up_ready", L1_LINE_W'(up_req_ready), '0);
    chk("rst_up_resp", L1_LINE_W'(up_resp_valid), '0);
    chk("rst_err", L1_LINE_W'(err_spur_resp), '0);

    // Single read with one-cycle grant latency.
    rdly_cfg = 2;
    push_txn(0, 1'b0, 32'h0000_0040, '0);
    @(posedge clk); #2;
    chk("lat_before_grant", L1_LINE_W'(dn_req_valid), '0);
    @(posedge clk); #2;
    chk("lat_grant_valid", L1_LINE_W'(dn_req_valid), 1);
    chk("lat_grant_busy", L1_LINE_W'(busy), 1);
    chk("lat_ready_same_cycle", L1_LINE_W'(up_req_ready), 1);
    drain("single_read");

    // Table-driven single transactions.
    foreach (vecs[k]) begin
      stall_cfg  = vecs[k].stall;
      stall_left = vecs[k].stall;
      rdly_cfg   = vecs[k].rdly;
      push_txn(vecs[k].src, vecs[k].rw, vecs[k].addr, vecs[k].wline);
      drain("vec");
    end

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    push_txn(0, 1'b1, 32'h0000_0400, {8{32'h0A0A_0A0A}});
    push_txn(1, 1'b1, 32'h0000_0500, {8{32'h1B1B_1B1B}});
    push_txn(0, 1'b1, 32'h0000_0440, {8{32'h2C2C_2C2C}});
    push_txn(1, 1'b1, 32'h0000_0540, {8{32'h3D3D_3D3D}});
    drain("contention");

    // Backpressure: L2 holds ready low for 5 cycles.
    stall_cfg = 5;
    stall_left = 5;
    stall_cycles = 0;
    push_txn(1, 1'b1, 32'h0000_0780, {8{32'h5555_AAAA}});
    drain("backpressure");
    chk("stall_len", L1_LINE_W'(stall_cycles), 5);
    stall_cfg = 0;
    stall_left = 0;

    // Writeback then refill from req1 with a read from req0 arriving in between.
    do_reset();
    rdly_cfg = 3;
    push_req(1, 1'b1, 32'h0000_0100, {8{32'hCAFE_F00D}});
    push_req(1, 1'b0, 32'h0000_0200, '0);
    push_exp(1, 1'b1, 32'h0000_0100, {8{32'hCAFE_F00D}});
    push_exp(0, 1'b0, 32'h0000_0300, '0);
    push_exp(1, 1'b0, 32'h0000_0200, '0);
    @(posedge clk); #2;
    push_req(0, 1'b0, 32'h0000_0300, '0);
    drain("wb_refill");

    // Spurious response while idle.
    do_reset();
    spur_mode = 1'b1;
    @(posedge clk); #2;
    dn_resp_rline = {8{32'h7777_7777}};
    dn_resp_valid = 1'b1;
    @(negedge clk);
    chk("spur_no_route", L1_LINE_W'(up_resp_valid), '0);
    chk("spur_no_rline", up_resp_rline, '0);
    chk("spur_err_before", L1_LINE_W'(err_spur_resp), '0);
    @(posedge clk); #2;
    dn_resp_valid = 1'b0;
    @(negedge clk);
    chk("spur_err_set", L1_LINE_W'(err_spur_resp), 1);
    chk("spur_busy", L1_LINE_W'(busy), '0);
    spur_mode = 1'b0;
    push_txn(1, 1'b1, 32'h0000_0900, {8{32'h0123_4567}});
    drain("after_spur");
    chk("spur_err_sticky", L1_LINE_W'(err_spur_resp), 1);

    // Reset while waiting for a read response, then a late response.
    rdly_cfg = 10;
    push_txn(0, 1'b0, 32'h0000_0A00, '0);
    for (int k = 0; k < 50 && !(busy && !dn_req_valid); k++) @(negedge clk);
    chk("reach_resp_wait", L1_LINE_W'(busy && !dn_req_valid), 1);
    rst = 1'b1;
    spur_mode = 1'b1;
    resp_pend = 1'b0;
    for (int i = 0; i < NREQ; i++) req_q[i].delete();
    exp_q.delete();
    resp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rstw_busy", L1_LINE_W'(busy), '0);
    chk("rstw_dn_valid", L1_LINE_W'(dn_req_valid), '0);
    chk("rstw_dn_addr", L1_LINE_W'(dn_req_addr), '0);
    chk("rstw_up_ready", L1_LINE_W'(up_req_ready), '0);
    chk("rstw_up_resp", L1_LINE_W'(up_resp_valid), '0);
    chk("rstw_rline", up_resp_rline, '0);
    chk("rstw_err", L1_LINE_W'(err_spur_resp), '0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    dn_resp_rline = {8{32'h9999_0000}};
    dn_resp_valid = 1'b1;
    @(negedge clk);
    chk("late_no_route", L1_LINE_W'(up_resp_valid), '0);
    @(posedge clk); #2;
    dn_resp_valid = 1'b0;
    @(negedge clk);
    chk("late_err_set", L1_LINE_W'(err_spur_resp), 1);

`ifdef L2ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_txn(0, 1'b1, ADDR_W'(32'h0000_1000 + k * 64), {8{32'h0}} | L1_LINE_W'(k));
      if (k < 3) push_txn(1, 1'b1, ADDR_W'(32'h0000_2000 + k * 64), {8{32'h1}});
    end
    drain("stats");
    chk("stat_grants0", L1_LINE_W'(stat_grants[0]), 4);
    chk("stat_grants1", L1_LINE_W'(stat_grants[1]), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
